// File: rtl/xz_scrub_feeder.sv
// Purpose : scrubs X/Z bits of incoming 4-state lane beats using the last known-good
//           value per bit, queues {data,mask,dirty} in a small valid/ready FIFO,
//           counts dirty beats and latches FAULT on a run of FAULT_THRESH dirty beats.
// Latency : an accepted beat reaches the head one cycle after acceptance (FIFO empty).
// Backpr. : in_ready is registered-only (FIFO not full and not in FAULT); no
//           combinational path from out_ready to in_ready.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/in_data upstream beat;
//           out_valid/out_ready/out_data/out_strobe/xz_mask FIFO head; dirty_count
//           saturating dirty-beat count; fault level; clr_fault one-cycle release pulse.
module xz_scrub_feeder #(
  parameter int LANES        = 3,
  parameter int DEPTH        = 2,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*LANES-1:0] out_data,
  output logic               out_strobe,
  output logic [2*LANES-1:0] xz_mask,
  output logic [CNT_W-1:0]   dirty_count,
  output logic               fault,
  input  logic               clr_fault
);
  localparam int W  = 2 * LANES;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Run counter only needs to reach FAULT_THRESH: accepts stop once it trips.
  localparam int RW = $clog2(FAULT_THRESH + 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic         dirty;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  entry_t           mem_q [DEPTH];
  entry_t           last_q;
  entry_t           head;
  entry_t           beat;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [W-1:0]     last_good_q;
  logic [CNT_W-1:0] dirty_cnt_q;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  state_t           state_q, state_d;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scrub: a bit that is neither 0 nor 1 takes last_good from before this beat.
  always_comb begin
    beat = '0;
    for (int b = 0; b < W; b++) begin
      if ((in_data[b] === 1'b0) || (in_data[b] === 1'b1)) begin
        beat.data[b] = in_data[b];
      end else begin
        beat.data[b] = last_good_q[b];
        beat.mask[b] = 1'b1;
      end
    end
    beat.dirty = |beat.mask;
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH)) && (state_q == RUN);
  assign fault     = (state_q == FAULT);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dirty_count = dirty_cnt_q;

  // When empty, present the last popped beat so the head outputs hold.
  always_comb begin
    out_data   = last_q.data;
    xz_mask    = last_q.mask;
    out_strobe = last_q.dirty;
    if (out_valid) begin
      out_data   = head.data;
      xz_mask    = head.mask;
      out_strobe = head.dirty;
    end
  end

  // FSM next state. Accepts only happen in RUN, so a trip can never coincide with
  // a clr_fault that is acted upon: the trip wins by construction.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      RUN: begin
        if (push) begin
          if (beat.dirty) begin
            run_cnt_d = run_cnt_q + 1'b1;
            if (run_cnt_d == RW'(FAULT_THRESH)) begin
              state_d = FAULT;
            end
          end else begin
            run_cnt_d = '0;
          end
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      last_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_good_q <= '0;
      dirty_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= beat;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
        // Unknown bits carry last_good in beat.data, so this updates known bits only.
        last_good_q     <= beat.data;
        if (beat.dirty && (dirty_cnt_q != '1)) begin
          dirty_cnt_q <= dirty_cnt_q + 1'b1;
        end
      end
      if (pop) begin
        last_q   <= head;
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xz_scrub_feeder.sv
`timescale 1ns/1ps
module tb_xz_scrub_feeder;
  localparam int W      = 6;
  localparam int DEPTH  = 2;
  localparam int THRESH = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic         strobe;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_valid2 = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_ready2 = 1'b1;
  logic         clr_fault = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready, out_valid, out_strobe, fault;
  logic [W-1:0] out_data, xz_mask;
  logic [7:0]   dirty_count;
  logic         in_ready2, out_valid2, out_strobe2, fault2;
  logic [W-1:0] out_data2, xz_mask2;
  logic [1:0]   dirty_count2;

  xz_scrub_feeder #(.LANES(3), .DEPTH(DEPTH), .CNT_W(8), .FAULT_THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_strobe(out_strobe), .xz_mask(xz_mask),
    .dirty_count(dirty_count), .fault(fault), .clr_fault(clr_fault)
  );

  // Narrow-counter instance; fed only during the saturation scenario.
  xz_scrub_feeder #(.LANES(3), .DEPTH(DEPTH), .CNT_W(2), .FAULT_THRESH(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_strobe(out_strobe2), .xz_mask(xz_mask2),
    .dirty_count(dirty_count2), .fault(fault2), .clr_fault(clr_fault)
  );

  always #5 clk = ~clk;

  exp_t         sb_q[$];
  logic [W-1:0] m_lg = '0;
  int           m_dirty = 0;
  int           m_dirty2 = 0;
  int           m_run = 0;
  logic         m_fault = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           fs = 1'b0;   // simulator keeps X/Z (4-state)

  function automatic exp_t scrub(input logic [W-1:0] d, input logic [W-1:0] lg);
    exp_t e;
    e = '0;
    for (int b = 0; b < W; b++) begin
      if ((d[b] === 1'b0) || (d[b] === 1'b1)) begin
        e.data[b] = d[b];
      end else begin
        e.data[b] = lg[b];
        e.mask[b] = 1'b1;
      end
    end
    e.strobe = |e.mask;
    return e;
  endfunction

  // Scoreboard monitor: compares on the falling edge, then advances the model
  // by the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    exp_t e;
    bit   rdy, acc, pop;
    if (!rst_n) begin
      sb_q.delete();
      m_lg = '0; m_dirty = 0; m_dirty2 = 0; m_run = 0; m_fault = 1'b0;
    end else begin
      rdy = (sb_q.size() < DEPTH) && !m_fault;
      n_checks++;
      if (out_valid !== (sb_q.size() != 0)) begin
        n_errors++;
        $display("FAIL mon_out_valid: got %b expected %b", out_valid, sb_q.size() != 0);
      end
      if (sb_q.size() != 0) begin
        n_checks++;
        if ({out_data, xz_mask, out_strobe} !== sb_q[0]) begin
          n_errors++;
          $display("FAIL mon_head: got data=%b mask=%b strobe=%b expected data=%b mask=%b strobe=%b",
                   out_data, xz_mask, out_strobe, sb_q[0].data, sb_q[0].mask, sb_q[0].strobe);
        end
      end
      n_checks++;
      if (in_ready !== rdy) begin
        n_errors++;
        $display("FAIL mon_in_ready: got %b expected %b", in_ready, rdy);
      end
      n_checks++;
      if (fault !== m_fault) begin
        n_errors++;
        $display("FAIL mon_fault: got %b expected %b", fault, m_fault);
      end
      n_checks++;
      if (dirty_count !== m_dirty[7:0]) begin
        n_errors++;
        $display("FAIL mon_dirty_count: got %0d expected %0d", dirty_count, m_dirty);
      end
      n_checks++;
      if (dirty_count2 !== m_dirty2[1:0]) begin
        n_errors++;
        $display("FAIL mon_dirty_count2: got %0d expected %0d", dirty_count2, m_dirty2);
      end
      pop = out_ready && (sb_q.size() != 0);
      acc = in_valid && rdy;
      if (pop) void'(sb_q.pop_front());
      if (acc) begin
        e = scrub(in_data, m_lg);
        sb_q.push_back(e);
        m_lg = e.data;
        if (e.strobe) begin
          if (m_dirty < 255) m_dirty++;
          m_run++;
          if (m_run == THRESH) m_fault = 1'b1;
        end else begin
          m_run = 0;
        end
      end else if (m_fault && clr_fault) begin
        m_fault = 1'b0;
        m_run   = 0;
      end
      if (in_valid2) begin
        n_checks++;
        if (in_ready2 !== 1'b1) begin
          n_errors++;
          $display("FAIL mon_in_ready2: got %b expected 1", in_ready2);
        end
        e = scrub(in_data, '0);
        if (e.strobe && (m_dirty2 < 3)) m_dirty2++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
    clr_fault = 1'b0; in_data = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_strobe, fault, in_ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_flags: got valid/strobe/fault/ready=%b expected 0001",
               {out_valid, out_strobe, fault, in_ready});
    end
    n_checks++;
    if ({out_data, xz_mask} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_head: got data=%b mask=%b expected zeros", out_data, xz_mask);
    end
    n_checks++;
    if (dirty_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_dirty_count: got %0d expected 0", dirty_count);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 6'b10_01_11;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data, xz_mask, out_strobe} !== {1'b1, 6'b100111, 6'b000000, 1'b0}) begin
      n_errors++;
      $display("FAIL basic_head: got valid=%b data=%b mask=%b strobe=%b expected 1 100111 000000 0",
               out_valid, out_data, xz_mask, out_strobe);
    end
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b0, 6'b100111}) begin
      n_errors++;
      $display("FAIL basic_hold_empty: got valid=%b data=%b expected 0 100111", out_valid, out_data);
    end
  endtask

  task automatic test_scrub();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 6'b10_01_11;
    tick();
    in_data = 6'b1x_0z_11;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scrub_model_empty: got 0 queued expected 1");
    end else if ({out_data, xz_mask, out_strobe} !== sb_q[0]) begin
      n_errors++;
      $display("FAIL scrub_head: got %b/%b/%b expected %b/%b/%b", out_data, xz_mask,
               out_strobe, sb_q[0].data, sb_q[0].mask, sb_q[0].strobe);
    end
    if (fs) begin
      n_checks++;
      if ({out_data, xz_mask, out_strobe, dirty_count} !== {6'b100111, 6'b010100, 1'b1, 8'd1}) begin
        n_errors++;
        $display("FAIL scrub_literal: got data=%b mask=%b strobe=%b dirty=%0d expected 100111 010100 1 1",
                 out_data, xz_mask, out_strobe, dirty_count);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 6'b000001;
    tick();
    in_data = 6'b101010;
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_full_ready: got %b expected 0", in_ready);
    end
    in_data = 6'b110011;
    tick();
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 6'b000001}) begin
      n_errors++;
      $display("FAIL bp_stall_head: got ready=%b valid=%b data=%b expected 0 1 000001",
               in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_data} !== {1'b1, 6'b101010}) begin
      n_errors++;
      $display("FAIL bp_pop1: got ready=%b data=%b expected 1 101010", in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 6'b110011}) begin
      n_errors++;
      $display("FAIL bp_push_pop: got ready=%b valid=%b data=%b expected 1 1 110011",
               in_ready, out_valid, out_data);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drained: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_fault();
    logic [W-1:0] dv [4];
    dv[0] = 6'b00_0x_01; dv[1] = 6'bz1_10_00; dv[2] = 6'b11_x0_1z; dv[3] = 6'b0x_x1_00;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = dv[i];
      tick();
    end
    in_valid = 1'b0;
    if (fs) begin
      n_checks++;
      if ({fault, in_ready} !== 2'b10) begin
        n_errors++;
        $display("FAIL fault_trip: got fault=%b ready=%b expected 1 0", fault, in_ready);
      end
    end
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fault_drain: got valid=%b expected 0", out_valid);
    end
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    n_checks++;
    if ({fault, in_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL fault_clear: got fault=%b ready=%b expected 0 1", fault, in_ready);
    end
    in_valid = 1'b1; in_data = dv[0];
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (fault !== 1'b0) begin
      n_errors++;
      $display("FAIL fault_fifth_beat: got %b expected 0", fault);
    end
    // Three more dirty beats; clr_fault coincides with the tripping one.
    in_valid = 1'b1;
    in_data = dv[1]; tick();
    in_data = dv[2]; tick();
    in_data = dv[3]; clr_fault = 1'b1; tick();
    clr_fault = 1'b0; in_valid = 1'b0;
    if (fs) begin
      n_checks++;
      if (fault !== 1'b1) begin
        n_errors++;
        $display("FAIL fault_trip_beats_clear: got %b expected 1", fault);
      end
    end
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    n_checks++;
    if (fault !== 1'b0) begin
      n_errors++;
      $display("FAIL fault_second_clear: got %b expected 0", fault);
    end
    repeat (3) tick();
  endtask

  task automatic test_saturate();
    logic [W-1:0] pv [8];
    pv[0] = 6'bx00000; pv[1] = 6'b000000; pv[2] = 6'b0z0000; pv[3] = 6'b111111;
    pv[4] = 6'b00x000; pv[5] = 6'b000z00; pv[6] = 6'b010101; pv[7] = 6'b00000x;
    do_reset();
    in_valid = 1'b0; in_valid2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = pv[i];
      tick();
    end
    in_valid2 = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (dirty_count2 !== m_dirty2[1:0]) begin
      n_errors++;
      $display("FAIL sat_count_model: got %0d expected %0d", dirty_count2, m_dirty2);
    end
    if (fs) begin
      n_checks++;
      if ({dirty_count2, fault2} !== {2'd3, 1'b0}) begin
        n_errors++;
        $display("FAIL sat_count_held: got count=%0d fault=%b expected 3 0", dirty_count2, fault2);
      end
    end
    n_checks++;
    if (dirty_count !== 8'd0) begin
      n_errors++;
      $display("FAIL sat_idle_instance: got %0d expected 0", dirty_count);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] dv [4];
    dv[0] = 6'b00_0x_01; dv[1] = 6'bz1_10_00; dv[2] = 6'b11_x0_1z; dv[3] = 6'b0x_x1_00;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = dv[i];
      tick();
    end
    out_ready = 1'b0; in_data = dv[3];
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL areset_pre: got valid=%b ready=%b expected 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, fault, dirty_count, out_data} !== {1'b0, 1'b0, 8'd0, 6'd0}) begin
      n_errors++;
      $display("FAIL areset_async: got valid=%b fault=%b dirty=%0d data=%b expected 0 0 0 000000",
               out_valid, fault, dirty_count, out_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL areset_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    logic probe;
    probe = 1'bx;
    fs = (probe !== 1'b0) && (probe !== 1'b1);
    test_reset();
    test_basic();
    test_scrub();
    test_backpressure();
    test_fault();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
